// File: rtl/inst_fetch_buffer.sv
// Sequential instruction prefetcher: issues word reads on the inst sram-like port and
// buffers returned instructions with their PCs in an in-order FIFO for the decode stage.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    input  logic        fs_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];

    logic [CW:0]   credit_s;
    logic          accept_s;
    logic          keep_s;
    logic          pop_s;
    logic          drop_s;
    logic [CW-1:0] count_nx_s;
    logic [CW-1:0] outstanding_nx_s;
    logic [CW-1:0] discard_nx_s;

    // Credit covers both buffered entries and accepted requests, so a response always has a slot.
    assign credit_s   = {1'b0, count_r} + {1'b0, outstanding_r};
    assign inst_req   = !reset && (credit_s < DEPTH_W);
    assign inst_addr  = fetch_pc_r;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'd2;
    assign inst_wdata = 32'h0000_0000;

    assign fs_valid = (count_r != {CW{1'b0}});
    assign fs_pc    = pc_mem_r[head_r];
    assign fs_inst  = inst_mem_r[head_r];

    // Next-state of the occupancy, in-flight and drop counters.
    always_comb begin
        accept_s         = inst_req && inst_addr_ok;
        pop_s            = fs_valid && fs_ready && !redirect;
        drop_s           = inst_data_ok && (discard_r != {CW{1'b0}});
        keep_s           = inst_data_ok && !drop_s && !redirect;
        outstanding_nx_s = outstanding_r + CW'(accept_s) - CW'(inst_data_ok);
        count_nx_s       = count_r;
        discard_nx_s     = discard_r;
        if (redirect) begin
            // Every response still in flight after this cycle belongs to the old stream.
            count_nx_s   = {CW{1'b0}};
            discard_nx_s = outstanding_nx_s;
        end else begin
            count_nx_s   = count_r + CW'(keep_s) - CW'(pop_s);
            discard_nx_s = discard_r - CW'(drop_s);
        end
    end

    // Fetch/response PCs, counters, FIFO pointers and storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            head_r        <= {PW{1'b0}};
            tail_r        <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                inst_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            count_r       <= count_nx_s;
            outstanding_r <= outstanding_nx_s;
            discard_r     <= discard_nx_s;
            if (redirect) begin
                fetch_pc_r <= redirect_pc;
                resp_pc_r  <= redirect_pc;
                head_r     <= {PW{1'b0}};
                tail_r     <= {PW{1'b0}};
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (keep_s) begin
                    pc_mem_r[tail_r]   <= resp_pc_r;
                    inst_mem_r[tail_r] <= inst_rdata;
                    tail_r             <= tail_r + {{(PW-1){1'b0}}, 1'b1};
                    resp_pc_r          <= resp_pc_r + 32'd4;
                end
                if (pop_s) begin
                    head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed per-cycle vectors, directed multi-cycle sequences,
// and random traffic from an in-order bridge model checked against a queue-based reference.
module tb_inst_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst),
        .fs_ready     (fs_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    // Starts high so the first negedge comes before the first sampling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c3ca5a5;
    endfunction

    typedef struct {
        logic        rst, aok, dok;
        logic [31:0] rdata;
        logic        rdy, redir;
        logic [31:0] rpc;
        logic        chk, e_req;
        logic [31:0] e_addr;
        logic        e_valid, chk_pc;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic aok, input logic dok, input logic [31:0] rdata,
                                input logic rdy, input logic redir, input logic [31:0] rpc, input logic c,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic chk_pc, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.aok = aok; v.dok = dok; v.rdata = rdata; v.rdy = rdy; v.redir = redir;
        v.rpc = rpc; v.chk = c; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.chk_pc = chk_pc; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    // Reference model: expected FIFO contents and in-flight requests ({keep, pc}).
    logic [63:0] m_fifo[$];
    logic [32:0] m_fly[$];
    logic [31:0] m_fetch;
    bit          m_sync = 1'b0;
    // Bridge model: accepted addresses with the cycle their response becomes due.
    logic [31:0] b_addr[$];
    int          b_due[$];
    int          cyc = 0;
    int          last_due = 0;
    // Stimulus knobs for cycle().
    bit          t_rst, t_rdy, t_aok, t_redir, hold_resp;
    logic [31:0] t_rpc;
    int          lat_min = 1;
    int          lat_max = 1;

    task automatic cycle();
        logic        dok;
        logic        mreq;
        logic        dreq;
        logic        mpop;
        logic [31:0] daddr;
        logic [32:0] f;
        int          d;
        dok = 1'b0;
        if (!t_rst && !hold_resp && b_addr.size() != 0) begin
            dok = (b_due[0] <= cyc);
        end
        mreq         = !t_rst && ((m_fifo.size() + m_fly.size()) < DEPTH);
        reset        = t_rst;
        inst_addr_ok = t_aok;
        inst_data_ok = dok;
        if (dok) inst_rdata = bdata(b_addr[0]);
        else     inst_rdata = $urandom();
        fs_ready     = t_rdy;
        redirect     = t_redir;
        redirect_pc  = t_rpc;
        @(negedge clk);
        if (m_sync) begin
            chk("req", 32'(inst_req), 32'(mreq));
            chk("addr", inst_addr, m_fetch);
            chk("valid", 32'(fs_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("pc", fs_pc, m_fifo[0][63:32]);
                chk("inst", fs_inst, m_fifo[0][31:0]);
            end
        end
        dreq  = inst_req;
        daddr = inst_addr;
        @(posedge clk);
        if (t_rst) begin
            m_fifo.delete(); m_fly.delete(); m_fetch = RESET_PC; m_sync = 1'b1;
            b_addr.delete(); b_due.delete(); last_due = 0;
        end else begin
            if (dok) begin
                void'(b_addr.pop_front());
                void'(b_due.pop_front());
            end
            if (dreq && t_aok) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                b_addr.push_back(daddr); b_due.push_back(d); last_due = d;
            end
            mpop = t_rdy && !t_redir && (m_fifo.size() != 0);
            if (mpop) void'(m_fifo.pop_front());
            if (dok && m_fly.size() != 0) begin
                f = m_fly.pop_front();
                if (f[32] && !t_redir) m_fifo.push_back({f[31:0], bdata(f[31:0])});
            end
            if (mreq && t_aok) begin
                m_fly.push_back({!t_redir, m_fetch});
                m_fetch = m_fetch + 32'd4;
            end
            if (t_redir) begin
                m_fifo.delete();
                foreach (m_fly[i]) m_fly[i][32] = 1'b0;
                m_fetch = t_rpc;
            end
        end
        cyc++;
        #1;
    endtask

    vec_t vecs[20];
    int   n;

    initial begin
        // rst aok dok rdata rdy redir rpc | chk req addr valid chk_pc pc inst
        vecs[0]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'hbfc00000, 0, 1, 32'h0,        32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00000, 0, 0, 32'h0,        32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00004, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 1, 32'h24080001, 1, 0, 32'h0,        1, 1, 32'hbfc00008, 0, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 1, 1, 32'h24090002, 1, 0, 32'h0,        1, 1, 32'hbfc0000c, 1, 1, 32'hbfc00000, 32'h24080001);
        vecs[6]  = mk(0, 0, 1, 32'h240a0003, 1, 0, 32'h0,        1, 1, 32'hbfc00010, 1, 1, 32'hbfc00004, 32'h24090002);
        vecs[7]  = mk(0, 0, 1, 32'h240b0004, 1, 0, 32'h0,        1, 1, 32'hbfc00010, 1, 1, 32'hbfc00008, 32'h240a0003);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00010, 1, 1, 32'hbfc0000c, 32'h240b0004);
        vecs[9]  = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00010, 0, 0, 32'h0,        32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0,        1, 1, 32'h80001000, 1, 1, 32'hbfc00014, 0, 0, 32'h0,        32'h0);
        vecs[11] = mk(0, 1, 1, 32'hdeadbeef, 1, 0, 32'h0,        1, 1, 32'h80001000, 0, 0, 32'h0,        32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h80001004, 0, 0, 32'h0,        32'h0);
        vecs[13] = mk(0, 0, 1, 32'h3c1d8000, 1, 0, 32'h0,        1, 1, 32'h80001004, 0, 0, 32'h0,        32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h80001004, 1, 1, 32'h80001000, 32'h3c1d8000);
        vecs[15] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h80001004, 0, 0, 32'h0,        32'h0);
        vecs[16] = mk(0, 1, 1, 32'h0bad0bad, 1, 1, 32'h00000100, 1, 1, 32'h80001008, 0, 0, 32'h0,        32'h0);
        vecs[17] = mk(0, 1, 1, 32'hdeadbeef, 1, 0, 32'h0,        1, 1, 32'h00000100, 0, 0, 32'h0,        32'h0);
        vecs[18] = mk(0, 0, 1, 32'h00851021, 0, 0, 32'h0,        1, 1, 32'h00000104, 0, 0, 32'h0,        32'h0);
        vecs[19] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h00000104, 1, 1, 32'h00000100, 32'h00851021);

        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst; inst_addr_ok = vecs[i].aok; inst_data_ok = vecs[i].dok;
            inst_rdata = vecs[i].rdata; fs_ready = vecs[i].rdy; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_req", i), 32'(inst_req), 32'(vecs[i].e_req));
                chk($sformatf("v%0d_addr", i), inst_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_valid", i), 32'(fs_valid), 32'(vecs[i].e_valid));
                if (vecs[i].chk_pc) begin
                    chk($sformatf("v%0d_pc", i), fs_pc, vecs[i].e_pc);
                    chk($sformatf("v%0d_inst", i), fs_inst, vecs[i].e_inst);
                end
            end
            @(posedge clk);
            #1;
        end

        // Stall: credit limits the FIFO plus in-flight to four, then one pop reopens fetch.
        t_redir = 1'b0; t_rpc = 32'h0; hold_resp = 1'b0;
        t_rst = 1'b1; t_rdy = 1'b0; t_aok = 1'b0;
        repeat (2) cycle();
        t_rst = 1'b0; t_aok = 1'b1; lat_min = 2; lat_max = 2;
        repeat (10) cycle();
        chk("t2_req_stall", 32'(inst_req), 32'd0);
        chk("t2_valid", 32'(fs_valid), 32'd1);
        chk("t2_head", fs_pc, 32'hbfc00000);
        t_rdy = 1'b1;
        cycle();
        t_rdy = 1'b0;
        chk("t2_req_resume", 32'(inst_req), 32'd1);
        chk("t2_addr_resume", inst_addr, 32'hbfc00010);
        chk("t2_head_after_pop", fs_pc, 32'hbfc00004);
        repeat (4) cycle();

        // count=3, outstanding=1, then a response together with a pop.
        t_rst = 1'b1; cycle();
        t_rst = 1'b0; hold_resp = 1'b1; t_aok = 1'b1; lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        chk("t5_req_full_credit", 32'(inst_req), 32'd0);
        t_aok = 1'b0; hold_resp = 1'b0;
        repeat (3) cycle();
        chk("t5_head", fs_pc, 32'hbfc00000);
        t_rdy = 1'b1;
        cycle();
        chk("t5_head_after_push_pop", fs_pc, 32'hbfc00004);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (fs_valid) n++;
            cycle();
        end
        chk("t5_entries_left", 32'(n), 32'd3);

        // Reset with two buffered entries and one request in flight.
        t_rst = 1'b1; cycle();
        t_rst = 1'b0; t_rdy = 1'b0; t_aok = 1'b1; lat_min = 2; lat_max = 2;
        repeat (3) cycle();
        t_aok = 1'b0;
        cycle();
        chk("t6_valid_before", 32'(fs_valid), 32'd1);
        t_rst = 1'b1;
        cycle();
        chk("t6_valid_reset", 32'(fs_valid), 32'd0);
        chk("t6_req_reset", 32'(inst_req), 32'd0);
        chk("t6_pc_cleared", fs_pc, 32'h0);
        chk("t6_addr_reset", inst_addr, 32'hbfc00000);
        t_rst = 1'b0; t_aok = 1'b1; t_rdy = 1'b1;
        repeat (8) cycle();

        // Random traffic, including redirects near the top of the address space.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r         = $urandom();
            t_rst     = ($urandom_range(299, 0) == 0);
            t_rdy     = ($urandom_range(3, 0) != 0);
            t_aok     = ($urandom_range(2, 0) != 0);
            t_redir   = ($urandom_range(19, 0) == 0);
            hold_resp = ($urandom_range(7, 0) == 0);
            lat_min   = 1;
            lat_max   = 4;
            if ($urandom_range(3, 0) == 0) t_rpc = 32'hfffffff8;
            else                           t_rpc = {r[31:2], 2'b00};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
